config_sequencer: RTL and testbench
===================================

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning: L1_NN 30, layer-1 neuron count; L1_NW 784, layer-1 weights per neuron; L2_NN 30, layer-2 neuron count; L2_NW 30, layer-2 weights per neuron; L3_NN 10, layer-3 neuron count; L3_NW 30, layer-3 weights per neuron.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a full configuration pass.
- s_data, in, 32: incoming weight/bias word.
- s_valid, in, 1: s_data valid.
- s_ready, out, 1: sequencer accepts a word this cycle.
- config_in, out, 32: word to the layers.
- config_valid, out, 1: config_in valid.
- config_type, out, 1: 0 = weight, 1 = bias.
- config_layer_num, out, 2: target layer, 1 to 3.
- config_neuron_num, out, 5: target neuron, zero-based.
- busy, out, 1: pass in progress.
- done, out, 1: one-cycle pulse when a pass completes.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD and FINISH.
REQ-004 Transitions SHALL be:
- IDLE to LOAD on start=1; layer=1, neuron=0 and wcnt=0 are loaded at the same time.
- LOAD to FINISH on acceptance of the final bias word of layer 3.
- FINISH to IDLE unconditionally after one cycle.
REQ-005 s_ready SHALL be 1 only in LOAD; a word is accepted exactly when s_valid and s_ready are both 1 on a clk edge.
REQ-006 Word order within a pass SHALL be: layer 1 to 3; within a layer, neuron 0 to NN-1; within a neuron, NW weight words (type 0) followed by exactly one bias word (type 1).
REQ-007 Outputs SHALL be registered with one-cycle latency: the cycle after each accepted word, config_valid=1 and config_in equals that word, with the type, layer and neuron of that word.
REQ-008 In all other cycles config_valid SHALL be 0, while config_in, config_type, config_layer_num and config_neuron_num hold their last values.
REQ-009 Counter rules on each accepted word:
- wcnt (10 bits) increments while wcnt < NW, and that word is a weight.
- When wcnt == NW, the word is the bias; wcnt then clears and neuron increments.
- When the bias of neuron NN-1 is accepted, neuron clears and layer increments.
REQ-010 NN and NW SHALL be selected from the current layer's parameters through a combinational mux; no counter may exceed its parameter.
REQ-011 busy SHALL be 1 in LOAD and FINISH and 0 in IDLE.
REQ-012 done SHALL be 1 for exactly the FINISH cycle, which is the cycle in which the final config_valid pulse is presented.
REQ-013 start asserted while busy=1 SHALL be ignored.
REQ-014 s_valid while in IDLE SHALL be ignored, and no word is consumed.
REQ-015 s_valid low mid-pass SHALL stall the pass with all counters held; gaps of any length are legal.
REQ-016 Back-to-back words SHALL be accepted at one per cycle with no bubbles.
REQ-017 With default parameters a pass SHALL accept exactly 24790 words: 30*785 + 30*31 + 10*31.

Reset
REQ-018 While rst=1 at a clk edge the block SHALL enter IDLE; counters go to 0, layer goes to 1, s_ready=0, config_valid=0, done=0 and busy=0.
REQ-019 config_in, config_type and config_neuron_num SHALL reset to 0, and config_layer_num SHALL reset to 1.
REQ-020 rst mid-pass SHALL abort the pass with no done pulse and no further config_valid; a subsequent start SHALL restart from layer 1, neuron 0, weight 0.

Structure
REQ-021 A shared package nn_cfg_pkg SHALL hold:
- the default layer constants (neuron counts, weights per neuron);
- the config_type encodings WEIGHT=0 and BIAS=1;
- the FSM state encodings.
REQ-022 The design SHALL be one module with no sub-modules.
REQ-023 The outputs SHALL connect directly to the config_* inputs of all three Layer instances.

Verification
REQ-024 Small pass (L1 2/3, L2 2/2, L3 1/2), start then 19 words with s_valid held high:
- 19 consecutive config_valid pulses.
- Layer/neuron/type sequence exactly as REQ-006.
- done coincides with the 19th pulse.
- busy drops the next cycle.
REQ-025 Same parameters with s_valid toggling 1,0,0,1 repeatedly:
- Same 19-word output sequence with matching gaps.
- Counters unchanged across gaps.
REQ-026 rst pulsed after word 7 of a pass:
- No done pulse; config_valid stays 0.
- A fresh start plus 19 words reproduces the REQ-024 sequence from layer 1, neuron 0.
REQ-027 start reasserted at word 5 of a pass, and s_valid=1 with data 0xDEADBEEF while in IDLE:
- No restart.
- No config_valid in IDLE.
- s_ready stays 0 in IDLE.
REQ-028 Default parameters, 24790 incrementing words 0..24789:
- Word 784 is the bias of layer 1, neuron 0.
- Word 23550 is the first weight of layer 2, neuron 0.
- The last word is the bias of layer 3, neuron 9, with done asserted alongside it.

Source files
------------

// File: rtl/nn_cfg_pkg.sv
// nn_cfg_pkg: constants shared by the network configuration logic.
//   - default layer geometry (neuron counts, weights per neuron)
//   - config_type encodings for the word presented to a layer
//   - state encodings of the configuration sequencer FSM
package nn_cfg_pkg;

  localparam int DEF_L1_NN = 30;
  localparam int DEF_L1_NW = 784;
  localparam int DEF_L2_NN = 30;
  localparam int DEF_L2_NW = 30;
  localparam int DEF_L3_NN = 10;
  localparam int DEF_L3_NW = 30;

  localparam logic CFG_WEIGHT = 1'b0;
  localparam logic CFG_BIAS   = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/config_sequencer.sv
// config_sequencer: streams weight/bias words into a three-layer network.
// A pass accepts, per layer and per neuron, NW weights followed by one bias,
// and tags each word with its type, layer and neuron on the config_* bus.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a configuration pass (ignored while busy)
//   s_data/s_valid      incoming word stream
//   s_ready             word accepted on clk edge when s_valid && s_ready
//   config_in/valid     registered word to the layers, one cycle after accept
//   config_type         0 = weight, 1 = bias
//   config_layer_num    target layer 1..3
//   config_neuron_num   target neuron, zero-based
//   busy                pass in progress
//   done                single-cycle pulse, coincides with last config_valid
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; s_ready low, stream words are not consumed
// LOAD   | accepting words; counters advance on every accepted word
// FINISH | final word is on config_in; done pulses, back to IDLE next
module config_sequencer
  import nn_cfg_pkg::*;
#(
  parameter int L1_NN = DEF_L1_NN,
  parameter int L1_NW = DEF_L1_NW,
  parameter int L2_NN = DEF_L2_NN,
  parameter int L2_NW = DEF_L2_NW,
  parameter int L3_NN = DEF_L3_NN,
  parameter int L3_NW = DEF_L3_NW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] config_in,
  output logic        config_valid,
  output logic        config_type,
  output logic [1:0]  config_layer_num,
  output logic [4:0]  config_neuron_num,
  output logic        busy,
  output logic        done
);

  logic [1:0] state;
  logic [1:0] layer;
  logic [4:0] neuron;
  logic [9:0] wcnt;

  logic [4:0] last_neuron;
  logic [9:0] nw_sel;
  logic       accept;
  logic       is_bias;

  // Geometry of the layer currently being loaded.
  always_comb begin
    last_neuron = 5'(L1_NN - 1);
    nw_sel      = 10'(L1_NW);
    case (layer)
      2'd2: begin
        last_neuron = 5'(L2_NN - 1);
        nw_sel      = 10'(L2_NW);
      end
      2'd3: begin
        last_neuron = 5'(L3_NN - 1);
        nw_sel      = 10'(L3_NW);
      end
      default: ;
    endcase
  end

  assign s_ready = (state == ST_LOAD);
  assign accept  = s_valid & s_ready;
  // wcnt has already counted all NW weights of this neuron: this word is the bias.
  assign is_bias = (wcnt == nw_sel);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      layer             <= 2'd1;
      neuron            <= '0;
      wcnt              <= '0;
      config_in         <= '0;
      config_valid      <= 1'b0;
      config_type       <= CFG_WEIGHT;
      config_layer_num  <= 2'd1;
      config_neuron_num <= '0;
    end else begin
      config_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_LOAD;
            layer  <= 2'd1;
            neuron <= '0;
            wcnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            config_valid      <= 1'b1;
            config_in         <= s_data;
            config_type       <= is_bias ? CFG_BIAS : CFG_WEIGHT;
            config_layer_num  <= layer;
            config_neuron_num <= neuron;
            if (!is_bias) begin
              wcnt <= wcnt + 10'd1;
            end else begin
              wcnt <= '0;
              if (neuron == last_neuron) begin
                neuron <= '0;
                if (layer == 2'd3) begin
                  // Wrap layer back to 1 so the counters never exceed their range.
                  layer <= 2'd1;
                  state <= ST_FINISH;
                end else begin
                  layer <= layer + 2'd1;
                end
              end else begin
                neuron <= neuron + 5'd1;
              end
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// tb_config_sequencer: self-checking bench for config_sequencer.
// A small-geometry instance exercises stalls, resets and ignored inputs;
// a default-geometry instance runs one full pass of 24790 words.
module tb_config_sequencer;

  typedef struct packed {
    logic       t;
    logic [1:0] l;
    logic [4:0] n;
  } tag_t;

  // Small geometry: layer1 3 neurons x 2 weights, layer2 2 x 2, layer3 2 x 1 -> 19 words.
  localparam int S1N = 3, S1W = 2, S2N = 2, S2W = 2, S3N = 2, S3W = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_start, s_svalid, s_ready, s_cvalid, s_ctype, s_busy, s_done;
  logic [31:0] s_sdata, s_cin;
  logic [1:0]  s_clayer;
  logic [4:0]  s_cneuron;

  logic        d_start, d_svalid, d_ready, d_cvalid, d_ctype, d_busy, d_done;
  logic [31:0] d_sdata, d_cin;
  logic [1:0]  d_clayer;
  logic [4:0]  d_cneuron;

  config_sequencer #(
    .L1_NN(S1N), .L1_NW(S1W), .L2_NN(S2N), .L2_NW(S2W), .L3_NN(S3N), .L3_NW(S3W)
  ) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .s_data(s_sdata), .s_valid(s_svalid),
    .s_ready(s_ready), .config_in(s_cin), .config_valid(s_cvalid),
    .config_type(s_ctype), .config_layer_num(s_clayer),
    .config_neuron_num(s_cneuron), .busy(s_busy), .done(s_done)
  );

  config_sequencer dut_d (
    .clk(clk), .rst(rst), .start(d_start), .s_data(d_sdata), .s_valid(d_svalid),
    .s_ready(d_ready), .config_in(d_cin), .config_valid(d_cvalid),
    .config_type(d_ctype), .config_layer_num(d_clayer),
    .config_neuron_num(d_cneuron), .busy(d_busy), .done(d_done)
  );

  int   errors = 0;
  int   checks = 0;
  tag_t sq[$];
  tag_t dq[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected word order: layers in order, neurons in order, NW weights then a bias.
  task automatic build_model(input int n1, input int w1, input int n2, input int w2,
                             input int n3, input int w3, output tag_t q[$]);
    int nn[3];
    int nw[3];
    nn = '{n1, n2, n3};
    nw = '{w1, w2, w3};
    q = {};
    for (int l = 0; l < 3; l++)
      for (int n = 0; n < nn[l]; n++)
        for (int w = 0; w <= nw[l]; w++)
          q.push_back(tag_t'{t: (w == nw[l]), l: 2'(l + 1), n: 5'(n)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (s_ready !== 1'b0 || s_cvalid !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b0 ||
        s_cin !== 32'h0 || s_ctype !== 1'b0 || s_clayer !== 2'd1 || s_cneuron !== 5'd0)
      begin
        errors++;
        $display("FAIL reset_small: rdy=%b vld=%b done=%b busy=%b in=%h type=%b layer=%0d neuron=%0d, required 0 0 0 0 0 0 1 0",
                 s_ready, s_cvalid, s_done, s_busy, s_cin, s_ctype, s_clayer, s_cneuron);
      end
    checks++;
    if (d_ready !== 1'b0 || d_cvalid !== 1'b0 || d_done !== 1'b0 || d_busy !== 1'b0 ||
        d_cin !== 32'h0 || d_clayer !== 2'd1)
      begin
        errors++;
        $display("FAIL reset_default: rdy=%b vld=%b done=%b busy=%b in=%h layer=%0d, required 0 0 0 0 0 1",
                 d_ready, d_cvalid, d_done, d_busy, d_cin, d_clayer);
      end
    rst = 1'b0;
    tick();
  endtask

  // mode 0: s_valid held high, 1: pattern 1,0,0,1, 2: random.
  // restart_at >= 0 re-asserts start alongside that word index.
  task automatic test_pass(input int mode, input int restart_at, input string name);
    int          idx;
    int          cyc;
    logic        v;
    logic        have_last;
    logic [31:0] d;
    logic [31:0] last_d;
    tag_t        e;
    tag_t        last_tag;
    idx       = 0;
    cyc       = 0;
    have_last = 1'b0;
    last_d    = '0;
    last_tag  = '0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    checks++;
    if (s_busy !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: busy=%b s_ready=%b, required 1 1", name, s_busy, s_ready);
    end
    while (idx < sq.size() && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d        = $urandom;
      s_svalid = v;
      s_sdata  = d;
      s_start  = v && (idx == restart_at);
      tick();
      cyc++;
      s_start  = 1'b0;
      s_svalid = 1'b0;
      checks++;
      if (v) begin
        e = sq[idx];
        if (s_cvalid !== 1'b1 || s_cin !== d || s_ctype !== e.t || s_clayer !== e.l ||
            s_cneuron !== e.n || s_done !== (idx == sq.size() - 1) || s_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s word %0d: vld=%b in=%h type=%b layer=%0d neuron=%0d done=%b busy=%b, required 1 %h %b %0d %0d %b 1",
                   name, idx, s_cvalid, s_cin, s_ctype, s_clayer, s_cneuron, s_done, s_busy,
                   d, e.t, e.l, e.n, (idx == sq.size() - 1));
        end
        last_d    = d;
        last_tag  = e;
        have_last = 1'b1;
        idx++;
      end else begin
        if (s_cvalid !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b1 ||
            (have_last && (s_cin !== last_d || s_ctype !== last_tag.t ||
                           s_clayer !== last_tag.l || s_cneuron !== last_tag.n))) begin
          errors++;
          $display("FAIL %s gap before word %0d: vld=%b done=%b busy=%b in=%h layer=%0d neuron=%0d, required 0 0 1 held %h %0d %0d",
                   name, idx, s_cvalid, s_done, s_busy, s_cin, s_clayer, s_cneuron,
                   last_d, last_tag.l, last_tag.n);
        end
      end
    end
    checks++;
    if (idx != sq.size()) begin
      errors++;
      $display("FAIL %s_timeout: words=%0d, required %0d", name, idx, sq.size());
    end
    tick();
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_cvalid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: busy=%b done=%b vld=%b rdy=%b, required 0 0 0 0",
               name, s_busy, s_done, s_cvalid, s_ready);
    end
  endtask

  task automatic test_idle_ignore();
    s_svalid = 1'b1;
    s_sdata  = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_ready !== 1'b0 || s_cvalid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore cycle %0d: rdy=%b vld=%b busy=%b done=%b, required 0 0 0 0",
                 i, s_ready, s_cvalid, s_busy, s_done);
      end
    end
    s_svalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    d = '0;
    for (int i = 0; i < 7; i++) begin
      d        = $urandom;
      s_svalid = 1'b1;
      s_sdata  = d;
      tick();
    end
    checks++;
    if (s_cvalid !== 1'b1 || s_cin !== d || s_ctype !== sq[6].t || s_clayer !== sq[6].l ||
        s_cneuron !== sq[6].n) begin
      errors++;
      $display("FAIL reset_mid word7: vld=%b in=%h type=%b layer=%0d neuron=%0d, required 1 %h %b %0d %0d",
               s_cvalid, s_cin, s_ctype, s_clayer, s_cneuron, d, sq[6].t, sq[6].l, sq[6].n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (s_cvalid !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b0 || s_ready !== 1'b0 ||
        s_clayer !== 2'd1 || s_cneuron !== 5'd0 || s_cin !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_abort: vld=%b done=%b busy=%b rdy=%b layer=%0d neuron=%0d in=%h, required 0 0 0 0 1 0 0",
               s_cvalid, s_done, s_busy, s_ready, s_clayer, s_cneuron, s_cin);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_cvalid !== 1'b0 || s_done !== 1'b0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d: vld=%b done=%b rdy=%b, required 0 0 0",
                 i, s_cvalid, s_done, s_ready);
      end
    end
    s_svalid = 1'b0;
  endtask

  task automatic test_default_pass();
    int bad;
    int first_bad;
    int last;
    int idx;
    bad       = 0;
    first_bad = -1;
    last      = dq.size() - 1;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    idx = 0;
    while (idx <= last) begin
      d_svalid = 1'b1;
      d_sdata  = 32'(idx);
      tick();
      if (d_cvalid !== 1'b1 || d_cin !== 32'(idx) || d_ctype !== dq[idx].t ||
          d_clayer !== dq[idx].l || d_cneuron !== dq[idx].n || d_done !== (idx == last)) begin
        bad++;
        if (first_bad < 0) first_bad = idx;
      end
      if (idx == 784) begin
        checks++;
        if (d_ctype !== 1'b1 || d_clayer !== 2'd1 || d_cneuron !== 5'd0 || d_cin !== 32'd784) begin
          errors++;
          $display("FAIL default_word784: type=%b layer=%0d neuron=%0d in=%0d, required 1 1 0 784",
                   d_ctype, d_clayer, d_cneuron, d_cin);
        end
      end
      if (idx == 23550) begin
        checks++;
        if (d_ctype !== 1'b0 || d_clayer !== 2'd2 || d_cneuron !== 5'd0 || d_cin !== 32'd23550) begin
          errors++;
          $display("FAIL default_word23550: type=%b layer=%0d neuron=%0d in=%0d, required 0 2 0 23550",
                   d_ctype, d_clayer, d_cneuron, d_cin);
        end
      end
      if (idx == 24789) begin
        checks++;
        if (d_ctype !== 1'b1 || d_clayer !== 2'd3 || d_cneuron !== 5'd9 || d_done !== 1'b1 ||
            d_cvalid !== 1'b1) begin
          errors++;
          $display("FAIL default_last: type=%b layer=%0d neuron=%0d done=%b vld=%b, required 1 3 9 1 1",
                   d_ctype, d_clayer, d_cneuron, d_done, d_cvalid);
        end
      end
      idx++;
    end
    d_svalid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL default_stream: bad_words=%0d first_at=%0d, required 0", bad, first_bad);
    end
    tick();
    checks++;
    if (d_busy !== 1'b0 || d_done !== 1'b0 || d_cvalid !== 1'b0) begin
      errors++;
      $display("FAIL default_end: busy=%b done=%b vld=%b, required 0 0 0", d_busy, d_done, d_cvalid);
    end
  endtask

  initial begin
    s_start = 1'b0; s_svalid = 1'b0; s_sdata = '0;
    d_start = 1'b0; d_svalid = 1'b0; d_sdata = '0;
    build_model(S1N, S1W, S2N, S2W, S3N, S3W, sq);
    build_model(30, 784, 30, 30, 10, 30, dq);
    test_reset();
    test_pass(0, -1, "solid");
    test_pass(1, -1, "toggle");
    test_pass(2, -1, "random");
    test_reset_mid();
    test_pass(0, -1, "after_reset");
    test_idle_ignore();
    test_pass(0, 5, "restart_ignored");
    test_default_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
